// File: rtl/mips_imm_pkg.sv
// Shared encodings for the immediate-extension stage: extension modes and skid-buffer states.
package mips_imm_pkg;

    typedef enum logic [1:0] {
        MODE_SIGN   = 2'b00,
        MODE_ZERO   = 2'b01,
        MODE_UPPER  = 2'b10,
        MODE_BRANCH = 2'b11
    } imm_mode_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_TWO   = 2'b10
    } buf_state_t;

endpackage

// File: rtl/imm_extend_core.sv
// Combinational immediate extender: sign, zero, upper (LUI) or branch offset (sign-extend << 2).
module imm_extend_core
    import mips_imm_pkg::*;
#(
    parameter int unsigned IN_W  = 16,
    parameter int unsigned OUT_W = 32
) (
    input  logic [IN_W-1:0]  imm,
    input  logic [1:0]       mode,
    output logic [OUT_W-1:0] data
);

    localparam int unsigned EXT_W = OUT_W - IN_W;

    logic [OUT_W-1:0] sext;

    assign sext = {{EXT_W{imm[IN_W-1]}}, imm};

    always_comb begin
        data = sext;
        case (mode)
            MODE_SIGN:   data = sext;
            MODE_ZERO:   data = {{EXT_W{1'b0}}, imm};
            MODE_UPPER:  data = {imm, {EXT_W{1'b0}}};
            MODE_BRANCH: data = {sext[OUT_W-3:0], 2'b00};
            default:     data = sext;
        endcase
    end

endmodule

// File: rtl/imm_extend_pipe.sv
// Pipelined immediate-extension stage with valid/ready handshake, 2-entry skid buffer and flush.
module imm_extend_pipe
    import mips_imm_pkg::*;
#(
    parameter int unsigned IN_W  = 16,
    parameter int unsigned OUT_W = 32,
    parameter int unsigned TAG_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_imm,
    input  logic [1:0]       in_mode,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic [TAG_W-1:0] out_tag
);

    if (IN_W < 2) begin : g_bad_in_w
        $error("imm_extend_pipe: IN_W must be at least 2");
    end
    if (OUT_W < IN_W + 2) begin : g_bad_out_w
        $error("imm_extend_pipe: OUT_W must be at least IN_W+2");
    end

    buf_state_t       state_q, state_d;
    logic             in_ready_q;
    logic [OUT_W-1:0] ext_data;
    logic [OUT_W-1:0] out_data_q, skid_data_q;
    logic [TAG_W-1:0] out_tag_q, skid_tag_q;
    logic             in_fire, out_fire;
    logic             load_out, load_skid, skid_to_out;

    imm_extend_core #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_core (
        .imm  (in_imm),
        .mode (in_mode),
        .data (ext_data)
    );

    assign in_ready  = in_ready_q;
    assign out_valid = (state_q != ST_EMPTY);
    assign out_data  = out_data_q;
    assign out_tag   = out_tag_q;
    assign in_fire   = in_valid && in_ready_q;
    assign out_fire  = out_valid && out_ready;

    always_comb begin
        state_d     = state_q;
        load_out    = 1'b0;
        load_skid   = 1'b0;
        skid_to_out = 1'b0;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_fire) begin
                        state_d  = ST_ONE;
                        load_out = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (in_fire && out_fire) begin
                        load_out = 1'b1;
                    end else if (in_fire) begin
                        state_d   = ST_TWO;
                        load_skid = 1'b1;
                    end else if (out_fire) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (out_fire) begin
                        state_d     = ST_ONE;
                        skid_to_out = 1'b1;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    // in_ready is registered from the next state so out_ready never reaches it combinationally
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_EMPTY;
            in_ready_q  <= 1'b1;
            out_data_q  <= '0;
            out_tag_q   <= '0;
            skid_data_q <= '0;
            skid_tag_q  <= '0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != ST_TWO);
            if (load_out) begin
                out_data_q <= ext_data;
                out_tag_q  <= in_tag;
            end else if (skid_to_out) begin
                out_data_q <= skid_data_q;
                out_tag_q  <= skid_tag_q;
            end
            if (load_skid) begin
                skid_data_q <= ext_data;
                skid_tag_q  <= in_tag;
            end
        end
    end

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Self-checking bench: two instances (16/32 and 12/20) against a queue-based reference model.
module tb_imm_extend_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush     [2];
    logic        in_valid  [2];
    logic        out_ready [2];
    logic [63:0] imm_a     [2];
    logic [1:0]  mode_a    [2];
    logic [4:0]  tag_a     [2];
    logic        in_ready  [2];
    logic        out_valid [2];
    logic [4:0]  otag      [2];
    logic [63:0] od        [2];
    logic [31:0] od0;
    logic [19:0] od1;

    int n_cmp = 0;
    int n_bad = 0;

    logic [63:0] qd [2][$];
    logic [4:0]  qt [2][$];
    logic        hold   [2];
    logic [63:0] prev_d [2];
    logic [4:0]  prev_t [2];

    logic [31:0] lit [4] = '{32'hFFFF8004, 32'h00008004, 32'h80040000, 32'hFFFE0010};

    always #5 clk = ~clk;

    assign od[0] = {32'b0, od0};
    assign od[1] = {44'b0, od1};

    imm_extend_pipe #(.IN_W(16), .OUT_W(32), .TAG_W(5)) u_dut0 (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush[0]),
        .in_valid  (in_valid[0]),
        .in_ready  (in_ready[0]),
        .in_imm    (imm_a[0][15:0]),
        .in_mode   (mode_a[0]),
        .in_tag    (tag_a[0]),
        .out_valid (out_valid[0]),
        .out_ready (out_ready[0]),
        .out_data  (od0),
        .out_tag   (otag[0])
    );

    imm_extend_pipe #(.IN_W(12), .OUT_W(20), .TAG_W(5)) u_dut1 (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush[1]),
        .in_valid  (in_valid[1]),
        .in_ready  (in_ready[1]),
        .in_imm    (imm_a[1][11:0]),
        .in_mode   (mode_a[1]),
        .in_tag    (tag_a[1]),
        .out_valid (out_valid[1]),
        .out_ready (out_ready[1]),
        .out_data  (od1),
        .out_tag   (otag[1])
    );

    // Reference extension from the mode rules using plain masks and shifts.
    function automatic logic [63:0] ref_ext(int k, logic [63:0] imm, logic [1:0] mode);
        int          iw;
        int          ow;
        logic [63:0] imask, omask, v, sx, r;
        iw    = (k == 0) ? 16 : 12;
        ow    = (k == 0) ? 32 : 20;
        imask = (64'd1 << iw) - 64'd1;
        omask = (64'd1 << ow) - 64'd1;
        v     = imm & imask;
        sx    = v[iw-1] ? (v | (omask & ~imask)) : v;
        case (mode)
            2'd0:    r = sx;
            2'd1:    r = v;
            2'd2:    r = (v << (ow - iw)) & omask;
            default: r = (sx << 2) & omask;
        endcase
        return r;
    endfunction

    task automatic chk(string name, logic [63:0] got, logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Compare process: entries in flight are exactly the model queue contents.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                qd[k].delete();
                qt[k].delete();
                hold[k] = 1'b0;
            end else begin
                chk($sformatf("in_ready[%0d]", k), 64'(in_ready[k]), 64'(qd[k].size() < 2));
                chk($sformatf("out_valid[%0d]", k), 64'(out_valid[k]), 64'(qd[k].size() > 0));
                if (hold[k]) begin
                    chk($sformatf("stable_data[%0d]", k), od[k], prev_d[k]);
                    chk($sformatf("stable_tag[%0d]", k), 64'(otag[k]), 64'(prev_t[k]));
                end
                if (flush[k]) begin
                    qd[k].delete();
                    qt[k].delete();
                    hold[k] = 1'b0;
                end else begin
                    if (out_valid[k] && out_ready[k] && qd[k].size() > 0) begin
                        chk($sformatf("out_data[%0d]", k), od[k], qd[k].pop_front());
                        chk($sformatf("out_tag[%0d]", k), 64'(otag[k]), 64'(qt[k].pop_front()));
                    end
                    if (in_valid[k] && in_ready[k]) begin
                        qd[k].push_back(ref_ext(k, imm_a[k], mode_a[k]));
                        qt[k].push_back(tag_a[k]);
                    end
                    hold[k]   = out_valid[k] && !out_ready[k];
                    prev_d[k] = od[k];
                    prev_t[k] = otag[k];
                end
            end
        end
    end

    initial begin
        reset = 1'b1;
        for (int k = 0; k < 2; k++) begin
            flush[k] = 1'b0; in_valid[k] = 1'b0; out_ready[k] = 1'b0;
            imm_a[k] = '0;   mode_a[k] = '0;    tag_a[k] = '0;
            hold[k] = 1'b0;  prev_d[k] = '0;    prev_t[k] = '0;
        end
        #2;
        for (int k = 0; k < 2; k++) begin
            chk("rst_out_valid", 64'(out_valid[k]), 64'd0);
            chk("rst_in_ready", 64'(in_ready[k]), 64'd1);
            chk("rst_out_data", od[k], 64'd0);
            chk("rst_out_tag", 64'(otag[k]), 64'd0);
        end
        tick();
        reset = 1'b0;
        tick();

        // Single transfers, one per mode, with literal expectations.
        for (int m = 0; m < 4; m++) begin
            in_valid[0] = 1'b1; imm_a[0] = 64'h8004; mode_a[0] = 2'(m); tag_a[0] = 5'(m);
            out_ready[0] = 1'b1;
            tick();
            in_valid[0] = 1'b0;
            chk("lat_valid", 64'(out_valid[0]), 64'd1);
            chk($sformatf("lit_mode%0d", m), od[0], 64'(lit[m]));
            tick();
            chk("lat_drain", 64'(out_valid[0]), 64'd0);
        end

        // Back-pressure: tags 1,2,3 with out_ready low.
        out_ready[0] = 1'b0; in_valid[0] = 1'b1; mode_a[0] = 2'd1; imm_a[0] = 64'h0011;
        tag_a[0] = 5'd1;
        tick();
        chk("bp_ready_after1", 64'(in_ready[0]), 64'd1);
        tag_a[0] = 5'd2; imm_a[0] = 64'h0022;
        tick();
        chk("bp_ready_after2", 64'(in_ready[0]), 64'd0);
        tag_a[0] = 5'd3; imm_a[0] = 64'h0033;
        tick();
        tick();
        chk("bp_held_ready", 64'(in_ready[0]), 64'd0);
        chk("bp_head_tag", 64'(otag[0]), 64'd1);
        out_ready[0] = 1'b1;
        tick();
        chk("bp_tag2", 64'(otag[0]), 64'd2);
        chk("bp_valid2", 64'(out_valid[0]), 64'd1);
        tick();
        in_valid[0] = 1'b0;
        chk("bp_tag3", 64'(otag[0]), 64'd3);
        chk("bp_data3", od[0], 64'h0033);
        tick();
        chk("bp_empty", 64'(out_valid[0]), 64'd0);

        // Sustained simultaneous fire.
        out_ready[0] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_valid[0] = 1'b1; imm_a[0] = 64'($urandom);
            mode_a[0] = 2'($urandom_range(0, 3)); tag_a[0] = 5'(i);
            tick();
            chk("tp_valid", 64'(out_valid[0]), 64'd1);
            chk("tp_ready", 64'(in_ready[0]), 64'd1);
            chk("tp_tag", 64'(otag[0]), 64'(i));
        end
        in_valid[0] = 1'b0;
        tick();

        // Flush in TWO with a concurrent input, then flush in ONE with an accepted input.
        out_ready[0] = 1'b0; in_valid[0] = 1'b1;
        tag_a[0] = 5'd10; tick();
        tag_a[0] = 5'd11; tick();
        flush[0] = 1'b1; tag_a[0] = 5'd12; tick();
        flush[0] = 1'b0; in_valid[0] = 1'b0;
        chk("fl2_valid", 64'(out_valid[0]), 64'd0);
        chk("fl2_ready", 64'(in_ready[0]), 64'd1);
        in_valid[0] = 1'b1; tag_a[0] = 5'd20; tick();
        flush[0] = 1'b1; tag_a[0] = 5'd21; tick();
        flush[0] = 1'b0; in_valid[0] = 1'b0; out_ready[0] = 1'b1;
        chk("fl1_valid", 64'(out_valid[0]), 64'd0);
        tick();
        chk("fl1_stays_empty", 64'(out_valid[0]), 64'd0);

        // Asynchronous reset between edges while full.
        out_ready[0] = 1'b0; in_valid[0] = 1'b1; imm_a[0] = 64'h1234; mode_a[0] = 2'd0;
        tag_a[0] = 5'd7;
        tick();
        tick();
        #2;
        reset = 1'b1;
        #1;
        chk("ar_out_valid", 64'(out_valid[0]), 64'd0);
        chk("ar_out_data", od[0], 64'd0);
        chk("ar_in_ready", 64'(in_ready[0]), 64'd1);
        chk("ar_out_tag", 64'(otag[0]), 64'd0);
        in_valid[0] = 1'b0;
        tick();
        reset = 1'b0;
        in_valid[0] = 1'b1; imm_a[0] = 64'h7FFF; mode_a[0] = 2'd0; tag_a[0] = 5'd9;
        out_ready[0] = 1'b1;
        tick();
        in_valid[0] = 1'b0;
        chk("ar_fresh_valid", 64'(out_valid[0]), 64'd1);
        chk("ar_fresh_data", od[0], 64'h0000_7FFF);
        tick();

        // Narrow instance literal checks.
        out_ready[1] = 1'b1;
        for (int j = 0; j < 2; j++) begin
            in_valid[1] = 1'b1; imm_a[1] = 64'hFFF; mode_a[1] = (j == 0) ? 2'd1 : 2'd3;
            tag_a[1] = 5'(j);
            tick();
            in_valid[1] = 1'b0;
            chk("p_valid", 64'(out_valid[1]), 64'd1);
            chk((j == 0) ? "p_zero" : "p_branch", od[1], (j == 0) ? 64'h00FFF : 64'hFFFFC);
            tick();
        end

        // Randomized traffic on both instances.
        for (int c = 0; c < 600; c++) begin
            for (int k = 0; k < 2; k++) begin
                in_valid[k]  = ($urandom_range(0, 3) != 0);
                out_ready[k] = ($urandom_range(0, 2) != 0);
                flush[k]     = ($urandom_range(0, 31) == 0);
                imm_a[k]     = {$urandom, $urandom};
                mode_a[k]    = 2'($urandom_range(0, 3));
                tag_a[k]     = 5'($urandom_range(0, 31));
            end
            tick();
        end
        for (int k = 0; k < 2; k++) begin
            in_valid[k] = 1'b0; flush[k] = 1'b0; out_ready[k] = 1'b1;
        end
        tick(); tick(); tick();
        for (int k = 0; k < 2; k++) begin
            chk("drain_empty", 64'(out_valid[k]), 64'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
